// File: rtl/branch_sequencer.sv
// Decode-stage branch resolver: waits for forwarded operands, redirects fetch on
// taken branches, issues $31 link writes and counts taken branches.
module branch_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        bgt,
    input  logic        beq,
    input  logic        blt,
    input  logic        rt_is_zero,
    input  logic        link_reg,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rs_ready,
    input  logic        rt_ready,
    input  logic [31:0] target_in,
    input  logic [31:0] pc_plus8,
    input  logic        if_ack,
    output logic        id_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic [15:0] taken_count
);

    typedef enum logic [1:0] {StIdle, StWaitOpnd, StRedirect} state_e;

    state_e      state_q, state_d;
    logic        bgt_q, beq_q, blt_q, rtz_q, link_q;
    logic [31:0] target_q, pc8_q;
    logic [31:0] redirect_pc_q, link_data_q;
    logic        link_we_q;
    logic [15:0] taken_count_q, taken_count_d;

    logic        in_wait;
    logic        eff_bgt, eff_beq, eff_blt, eff_rtz, eff_link;
    logic [31:0] eff_target, eff_pc8, b_val;
    logic        is_br, opnd_ready, taken, resolve, capture;

    // Decode flags come live in IDLE and from the latched copy while waiting for operands
    always_comb begin
        in_wait    = (state_q == StWaitOpnd);
        eff_bgt    = in_wait ? bgt_q    : bgt;
        eff_beq    = in_wait ? beq_q    : beq;
        eff_blt    = in_wait ? blt_q    : blt;
        eff_rtz    = in_wait ? rtz_q    : rt_is_zero;
        eff_link   = in_wait ? link_q   : link_reg;
        eff_target = in_wait ? target_q : target_in;
        eff_pc8    = in_wait ? pc8_q    : pc_plus8;
        is_br      = eff_bgt | eff_beq | eff_blt;
        opnd_ready = rs_ready & (rt_ready | eff_rtz);
        b_val      = eff_rtz ? 32'd0 : rt_val;
        taken      = (eff_bgt & ($signed(rs_val) >  $signed(b_val)))
                   | (eff_beq & ($signed(rs_val) == $signed(b_val)))
                   | (eff_blt & ($signed(rs_val) <  $signed(b_val)));
        // A flush (id_valid low) beats operand arrival in WAIT_OPND
        resolve    = id_valid & is_br & opnd_ready & ((state_q == StIdle) | in_wait);
        capture    = (state_q == StIdle) & id_valid & is_br & ~opnd_ready;
        taken_count_d = taken_count_q;
        if (resolve && taken && taken_count_q != 16'hFFFF) begin
            taken_count_d = taken_count_q + 16'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (resolve) begin
                    state_d = taken ? StRedirect : StIdle;
                end else if (capture) begin
                    state_d = StWaitOpnd;
                end
            end
            StWaitOpnd: begin
                if (!id_valid) begin
                    state_d = StIdle;
                end else if (opnd_ready) begin
                    state_d = taken ? StRedirect : StIdle;
                end
            end
            StRedirect: begin
                if (if_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; stall is gated by reset so it reads low while rst_n is held
    always_comb begin
        id_stall       = 1'b0;
        redirect_valid = (state_q == StRedirect);
        unique case (state_q)
            StIdle:     id_stall = capture;
            StWaitOpnd: id_stall = ~opnd_ready & id_valid;
            StRedirect: id_stall = ~if_ack;
            default:    id_stall = 1'b0;
        endcase
        id_stall    = id_stall & rst_n;
        redirect_pc = redirect_pc_q;
        link_we     = link_we_q;
        link_data   = link_data_q;
        taken_count = taken_count_q;
    end

    // Latched branch context, resolution results and taken counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bgt_q         <= 1'b0;
            beq_q         <= 1'b0;
            blt_q         <= 1'b0;
            rtz_q         <= 1'b0;
            link_q        <= 1'b0;
            target_q      <= 32'd0;
            pc8_q         <= 32'd0;
            redirect_pc_q <= 32'd0;
            link_we_q     <= 1'b0;
            link_data_q   <= 32'd0;
            taken_count_q <= 16'd0;
        end else begin
            if (capture) begin
                bgt_q    <= bgt;
                beq_q    <= beq;
                blt_q    <= blt;
                rtz_q    <= rt_is_zero;
                link_q   <= link_reg;
                target_q <= target_in;
                pc8_q    <= pc_plus8;
            end
            if (resolve && taken) begin
                redirect_pc_q <= eff_target;
            end
            link_we_q <= resolve & eff_link;
            if (resolve && eff_link) begin
                link_data_q <= eff_pc8;
            end
            taken_count_q <= taken_count_d;
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with immediate-assertion checks.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, bgt, beq, blt, rt_is_zero, link_reg;
    logic [31:0] rs_val, rt_val, target_in, pc_plus8;
    logic        rs_ready, rt_ready, if_ack;
    logic        id_stall, redirect_valid, link_we;
    logic [31:0] redirect_pc, link_data;
    logic [15:0] taken_count;

    int checks = 0;
    int errors = 0;

    branch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .bgt            (bgt),
        .beq            (beq),
        .blt            (blt),
        .rt_is_zero     (rt_is_zero),
        .link_reg       (link_reg),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .rs_ready       (rs_ready),
        .rt_ready       (rt_ready),
        .target_in      (target_in),
        .pc_plus8       (pc_plus8),
        .if_ack         (if_ack),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .link_we        (link_we),
        .link_data      (link_data),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 0; bgt = 0; beq = 0; blt = 0; rt_is_zero = 0; link_reg = 0;
        rs_val = 0; rt_val = 0; rs_ready = 0; rt_ready = 0;
        target_in = 0; pc_plus8 = 0; if_ack = 0;
    endtask

    // Unconditional jump: presented in IDLE, resolves at the next edge
    task automatic jump(input logic [31:0] tgt);
        id_valid = 1; bgt = 1; beq = 1; blt = 1; rs_ready = 1; rt_ready = 1;
        target_in = tgt;
        tick();
        clear_in();
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        // Would stall in IDLE if not held in reset
        id_valid = 1; beq = 1;
        #2;
        chk("rst_stall", id_stall, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_lwe", link_we, 0);
        chk("rst_ldata", link_data, 0);
        chk("rst_cnt", taken_count, 0);
        clear_in();
        #10 rst_n = 1;
        tick();

        // BEQ 5==5, both ready
        id_valid = 1; beq = 1; rs_val = 5; rt_val = 5; rs_ready = 1; rt_ready = 1;
        target_in = 32'h400;
        #1 chk("beq_stall", id_stall, 0);
        tick();
        clear_in();
        #1;
        chk("beq_rv", redirect_valid, 1);
        chk("beq_rpc", redirect_pc, 32'h400);
        chk("beq_cnt", taken_count, 1);
        chk("beq_lwe", link_we, 0);
        chk("beq_stall_noack", id_stall, 1);
        if_ack = 1;
        #1 chk("beq_stall_ack", id_stall, 0);
        tick();
        if_ack = 0;
        chk("beq_idle", redirect_valid, 0);

        // BGEZ-style (bgt|beq vs zero) with rs = -1: not taken
        id_valid = 1; bgt = 1; beq = 1; rt_is_zero = 1; rs_val = 32'hFFFF_FFFF;
        rs_ready = 1; rt_ready = 0; rt_val = 32'h8000_0000; target_in = 32'h500;
        #1 chk("bgtz_stall", id_stall, 0);
        tick();
        clear_in();
        #1;
        chk("bgtz_rv", redirect_valid, 0);
        chk("bgtz_cnt", taken_count, 1);
        chk("bgtz_lwe", link_we, 0);
        chk("bgtz_stall2", id_stall, 0);

        // BLTZAL rs = -3, rs not ready for three cycles
        id_valid = 1; blt = 1; rt_is_zero = 1; link_reg = 1; rs_val = 32'hFFFF_FFFD;
        rs_ready = 0; target_in = 32'h800; pc_plus8 = 32'h1008;
        #1 chk("bltzal_stall1", id_stall, 1);
        tick();
        // Live decode fields change; the latched copy must be used
        blt = 0; rt_is_zero = 0; link_reg = 0; rt_val = 32'h7;
        target_in = 32'hDEAD_0000; pc_plus8 = 32'h0000_0BAD;
        #1 chk("bltzal_stall2", id_stall, 1);
        tick();
        chk("bltzal_stall3", id_stall, 1);
        chk("bltzal_wait_rv", redirect_valid, 0);
        tick();
        rs_ready = 1;
        #1 chk("bltzal_ready_stall", id_stall, 0);
        tick();
        clear_in();
        if_ack = 1;
        #1;
        chk("bltzal_rv", redirect_valid, 1);
        chk("bltzal_rpc", redirect_pc, 32'h800);
        chk("bltzal_lwe", link_we, 1);
        chk("bltzal_ldata", link_data, 32'h1008);
        chk("bltzal_cnt", taken_count, 2);
        tick();
        if_ack = 0;
        chk("bltzal_lwe_pulse", link_we, 0);
        chk("bltzal_idle", redirect_valid, 0);
        chk("bltzal_ldata_hold", link_data, 32'h1008);

        // Redirect held for four cycles without ack
        jump(32'hC00);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold_rv%0d", i), redirect_valid, 1);
            chk($sformatf("hold_stall%0d", i), id_stall, 1);
            chk($sformatf("hold_rpc%0d", i), redirect_pc, 32'hC00);
            tick();
        end
        if_ack = 1;
        #1;
        chk("hold_ack_stall", id_stall, 0);
        chk("hold_ack_rv", redirect_valid, 1);
        tick();
        if_ack = 0;
        chk("hold_idle", redirect_valid, 0);
        chk("hold_cnt", taken_count, 3);

        // Flush in WAIT_OPND coinciding with operand arrival
        id_valid = 1; beq = 1; link_reg = 1; rs_val = 7; rt_val = 7;
        rs_ready = 0; rt_ready = 1; target_in = 32'h900; pc_plus8 = 32'h2008;
        tick();
        clear_in();
        rs_ready = 1; rt_ready = 1; rs_val = 7; rt_val = 7;
        #1 chk("flush_stall", id_stall, 0);
        tick();
        chk("flush_rv", redirect_valid, 0);
        chk("flush_lwe", link_we, 0);
        chk("flush_cnt", taken_count, 3);
        chk("flush_ldata", link_data, 32'h1008);

        // Non-branch with operands not ready: ignored
        clear_in();
        id_valid = 1;
        #1 chk("nonbr_stall", id_stall, 0);
        tick();
        chk("nonbr_rv", redirect_valid, 0);
        clear_in();

        // Preload counter close to saturation across one idle edge
        force dut.taken_count_q = 16'hFFFD;
        tick();
        release dut.taken_count_q;
        #1 chk("sat_preload", taken_count, 16'hFFFD);
        jump(32'hA00);
        chk("sat_cnt1", taken_count, 16'hFFFE);
        if_ack = 1;
        tick();
        jump(32'hA04);
        chk("sat_cnt2", taken_count, 16'hFFFF);
        if_ack = 1;
        tick();
        jump(32'hA08);
        chk("sat_cnt3", taken_count, 16'hFFFF);
        chk("sat_rv", redirect_valid, 1);
        chk("sat_rpc", redirect_pc, 32'hA08);

        // Reset asserted mid-REDIRECT
        #2 rst_n = 0;
        #1;
        chk("mid_rst_rv", redirect_valid, 0);
        chk("mid_rst_rpc", redirect_pc, 0);
        chk("mid_rst_lwe", link_we, 0);
        chk("mid_rst_ldata", link_data, 0);
        chk("mid_rst_cnt", taken_count, 0);
        chk("mid_rst_stall", id_stall, 0);
        #10 rst_n = 1;
        tick();
        chk("post_rst_rv", redirect_valid, 0);

        // Reset asserted mid-WAIT_OPND abandons the linking branch
        id_valid = 1; blt = 1; rt_is_zero = 1; link_reg = 1; rs_val = 32'hFFFF_FFFF;
        rs_ready = 0; pc_plus8 = 32'h3008; target_in = 32'hB00;
        tick();
        #2 rst_n = 0;
        clear_in();
        #10 rst_n = 1;
        id_valid = 1; rs_ready = 1;
        tick();
        chk("wait_rst_lwe", link_we, 0);
        chk("wait_rst_rv", redirect_valid, 0);
        tick();
        chk("wait_rst_lwe2", link_we, 0);
        chk("wait_rst_ldata", link_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
